pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Owns the program counter and fetches instruction words from instruction memory over a req/ack handshake.
- Presents each fetched word, with its PC, to the instruction decoder.
- Holds the word until the core signals that execution is complete.
- Computes the next PC from the decoder's 2-bit next-PC select, a branch-taken flag, the immediate and rs1. Traps on misaligned targets and memory errors.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned.
- XLEN, 32, width of PC, addresses, instruction word, immediate and rs1.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- imem_req  out  1  fetch request, held high until imem_ack
- imem_addr  out  XLEN  fetch address; equals pc_out, stable while imem_req=1
- imem_ack  in  1  memory returns data this cycle; sampled only when imem_req=1
- imem_rdata  in  XLEN  instruction word, valid with imem_ack
- imem_err  in  1  access fault, valid with imem_ack
- instr_out  out  XLEN  latched instruction word to the decoder
- instr_valid  out  1  instr_out/pc_out hold a live instruction
- pc_out  out  XLEN  PC of the current instruction
- instr_ready  in  1  core finished executing current instruction; sampled only when instr_valid=1
- sel_bit_mux  in  2  next-PC select from decoder: 00 pc+4, 01 branch, 10 jalr, 11 jal
- branch_taken  in  1  branch comparator result; used only when sel_bit_mux=01
- imm  in  XLEN  sign-extended immediate
- rs1_val  in  XLEN  register rs1 value, used for jalr
- trap  out  1  sticky fault flag
- trap_cause  out  2  00 none, 01 misaligned target, 10 imem error
- instret  out  32  count of retired instructions, wraps modulo 2^32

Behaviour:
- States: IDLE, FETCH, EXEC, TRAP.
- Reset (async, immediate, any state):
  - state=IDLE, pc=RESET_PC, instr_out=0, instr_valid=0, imem_req=0, trap=0, trap_cause=00, instret=0.
  - An outstanding memory request is abandoned; a late ack is ignored.
- IDLE: imem_req=0. Unconditionally moves to FETCH on the next edge, so the first request appears 1 cycle after reset release.
- FETCH: imem_req=1, imem_addr=pc. Waits any number of cycles for ack.
  - ack with imem_err=0: latch instr_out=imem_rdata, instr_valid=1, go to EXEC. imem_req drops the cycle after ack.
  - ack with imem_err=1: go to TRAP, trap_cause=10, instr_valid stays 0.
  - Minimum latency is 1 cycle, with ack in the same cycle the request is first high.
- EXEC: imem_req=0, instr_valid=1, instr_out and pc_out stable.
  - On instr_ready=1, compute next_pc:
    - 00: pc+4
    - 01: branch_taken ? pc+imm : pc+4
    - 10: (rs1_val+imm) with bit0 cleared
    - 11: pc+imm
  - All adds are XLEN-bit and wrap silently.
  - If next_pc[1:0]==00: pc<=next_pc, instret<=instret+1, instr_valid<=0, go to FETCH.
  - Otherwise: instret still increments (the jump/branch retired), pc is unchanged, trap_cause=01, go to TRAP.
  - Decode inputs are sampled only in the instr_ready cycle.
- Total cost is at least 2 cycles per instruction: ack in FETCH plus instr_ready in EXEC.
- TRAP: imem_req=0, instr_valid=0, trap=1, trap_cause held. Only rst leaves TRAP. instr_ready and imem_ack are ignored.
- imem_ack outside FETCH is ignored. instr_ready outside EXEC is ignored.
- instret wraps from 32'hFFFF_FFFF to 0 with no flag.

Decomposition:
- Shared package holds:
  - state enum (IDLE, FETCH, EXEC, TRAP)
  - next-PC select codes NPC_SEQ=2'b00, NPC_BR=2'b01, NPC_JALR=2'b10, NPC_JAL=2'b11, which the decoder also uses
  - trap cause codes
  - default RESET_PC
- One combinational sub-module, next_pc_calc: inputs pc, sel, branch_taken, imm, rs1_val; outputs next_pc and misaligned. It is unit-tested separately.

Test Plan:
- Reset, then ack on the first request cycle with rdata=32'h00500093 -> imem_req rises 1 cycle after rst falls, addr=0. Next cycle instr_valid=1, instr_out=32'h00500093, pc_out=0.
- Three sequential instructions (sel=00), ack latency 3 cycles, instr_ready 2 cycles after valid -> fetch addresses 0,4,8; instret=3; imem_addr stable through each wait.
- pc=0x20, sel=01, imm=-8:
  - branch_taken=1 -> next fetch at 0x18.
  - Repeat with branch_taken=0 -> next fetch at 0x24.
- jal/jalr targets:
  - sel=10, rs1_val=0x103, imm=1 -> target 0x104, fetch at 0x104.
  - sel=10, rs1_val=0x101, imm=1 -> target 0x102, trap=1, trap_cause=01, pc_out unchanged, no further imem_req.
  - sel=11, imm=0x6 -> trap_cause=01.
- Fault and reset handling:
  - imem_err=1 with ack -> trap_cause=10, instr_valid never rises.
  - rst pulsed mid-FETCH, with ack arriving after release before the new request -> ack ignored, fetch restarts at RESET_PC.
- Force instret=32'hFFFF_FFFF, retire one instruction -> instret=0, no trap.

Source files
------------

// File: rtl/pc_fetch_unit_pkg.sv
// pc_fetch_unit_pkg: shared FSM states, next-PC select codes, trap causes and reset PC
package pc_fetch_unit_pkg;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_FETCH = 2'd1;
  localparam state_t ST_EXEC  = 2'd2;
  localparam state_t ST_TRAP  = 2'd3;
  localparam logic [1:0] NPC_SEQ  = 2'b00;
  localparam logic [1:0] NPC_BR   = 2'b01;
  localparam logic [1:0] NPC_JALR = 2'b10;
  localparam logic [1:0] NPC_JAL  = 2'b11;
  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_IMEM     = 2'b10;
endpackage

// File: rtl/pc_fetch_unit_next_pc.sv
// next_pc_calc: selects the next PC from the decoder select and flags misaligned targets
module next_pc_calc
  import pc_fetch_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic [1:0]      sel_i,
  input  logic            branch_taken_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] rs1_val_i,
  output logic [XLEN-1:0] next_pc_o,
  output logic            misaligned_o
);
  logic [XLEN-1:0] jalr_sum;
  logic            rel_jump;
  // jalr clears bit 0 of the sum; pc-relative targets cover jal and taken branches
  always_comb begin
    jalr_sum     = rs1_val_i + imm_i;
    rel_jump     = (sel_i == NPC_JAL) || (sel_i == NPC_BR && branch_taken_i);
    next_pc_o    = (sel_i == NPC_JALR) ? {jalr_sum[XLEN-1:1], 1'b0}
                 : rel_jump ? pc_i + imm_i : pc_i + XLEN'(4);
    misaligned_o = |next_pc_o[1:0];
  end
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: owns the PC, fetches words over req/ack and holds them until retired
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int             XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            imem_err,
  output logic [XLEN-1:0] instr_out,
  output logic            instr_valid,
  output logic [XLEN-1:0] pc_out,
  input  logic            instr_ready,
  input  logic [1:0]      sel_bit_mux,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_val,
  output logic            trap,
  output logic [1:0]      trap_cause,
  output logic [31:0]     instret
);
  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, instr_q, instr_d, next_pc;
  logic [1:0]      cause_q, cause_d;
  logic [31:0]     instret_q, instret_d;
  logic            misaligned;

  next_pc_calc #(.XLEN(XLEN)) u_next_pc (
    .pc_i(pc_q), .sel_i(sel_bit_mux), .branch_taken_i(branch_taken), .imm_i(imm),
    .rs1_val_i(rs1_val), .next_pc_o(next_pc), .misaligned_o(misaligned)
  );

  assign imem_req    = state_q == ST_FETCH;
  assign imem_addr   = pc_q;
  assign pc_out      = pc_q;
  assign instr_out   = instr_q;
  assign instr_valid = state_q == ST_EXEC;
  assign trap        = state_q == ST_TRAP;
  assign trap_cause  = cause_q;
  assign instret     = instret_q;

  // Fetch/execute sequencing; ack only counts in FETCH and ready only in EXEC
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    cause_d   = cause_q;
    instret_d = instret_q;
    case (state_q)
      ST_IDLE:  state_d = ST_FETCH;
      ST_FETCH: if (imem_ack) begin
        state_d = imem_err ? ST_TRAP : ST_EXEC;
        cause_d = imem_err ? CAUSE_IMEM : cause_q;
        instr_d = imem_err ? instr_q : imem_rdata;
      end
      ST_EXEC:  if (instr_ready) begin
        instret_d = instret_q + 32'd1;
        state_d   = misaligned ? ST_TRAP : ST_FETCH;
        cause_d   = misaligned ? CAUSE_MISALIGN : cause_q;
        pc_d      = misaligned ? pc_q : next_pc;
      end
      default:  state_d = ST_TRAP;
    endcase
  end

  // State registers; reset abandons any outstanding request immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      cause_q   <= CAUSE_NONE;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      cause_q   <= cause_d;
      instret_q <= instret_d;
    end
  end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed scenario tests for pc_fetch_unit
module tb_pc_fetch_unit;
  logic        clk = 0, rst = 1, imem_ack = 0, imem_err = 0, instr_ready = 0, branch_taken = 0;
  logic [31:0] imem_rdata = 0, imm = 0, rs1_val = 0;
  logic [1:0]  sel_bit_mux = 0;
  logic        imem_req, instr_valid, trap;
  logic [31:0] imem_addr, instr_out, pc_out, instret;
  logic [1:0]  trap_cause;
  int n_chk = 0, n_fail = 0;

  pc_fetch_unit dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .imem_err(imem_err), .instr_out(instr_out), .instr_valid(instr_valid),
    .pc_out(pc_out), .instr_ready(instr_ready), .sel_bit_mux(sel_bit_mux), .branch_taken(branch_taken),
    .imm(imm), .rs1_val(rs1_val), .trap(trap), .trap_cause(trap_cause), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1; imem_ack = 0; imem_err = 0; instr_ready = 0;
    @(negedge clk); @(negedge clk);
    rst = 0;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 20 && !imem_req; i++) @(negedge clk);
    n_chk++;
    if (imem_req !== 1'b1) begin n_fail++; $display("FAIL wait_req: imem_req=%b required 1 within 20 cycles", imem_req); end
  endtask

  task automatic ack_word(input logic [31:0] d, input logic e);
    imem_ack = 1; imem_rdata = d; imem_err = e;
    @(negedge clk);
    imem_ack = 0; imem_rdata = 0; imem_err = 0;
  endtask

  task automatic retire(input logic [1:0] s, input logic bt, input logic [31:0] im, input logic [31:0] r);
    instr_ready = 1; sel_bit_mux = s; branch_taken = bt; imm = im; rs1_val = r;
    @(negedge clk);
    instr_ready = 0; sel_bit_mux = 0; branch_taken = 0; imm = 0; rs1_val = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    @(negedge clk);
    n_chk++;
    if ({imem_req, instr_valid, trap, trap_cause} !== 5'b0) begin n_fail++; $display("FAIL reset_ctrl: req/valid/trap/cause=%b required 00000", {imem_req, instr_valid, trap, trap_cause}); end
    n_chk++;
    if ({pc_out, instr_out, instret} !== 96'h0) begin n_fail++; $display("FAIL reset_regs: pc=%h instr=%h instret=%h required 0", pc_out, instr_out, instret); end
    rst = 0;
    n_chk++;
    if (imem_req !== 1'b0) begin n_fail++; $display("FAIL idle_req: imem_req=%b required 0", imem_req); end
    @(negedge clk);
    n_chk++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL first_req: req=%b addr=%h required 1/0", imem_req, imem_addr); end
    ack_word(32'h0050_0093, 0);
    n_chk++;
    if (instr_valid !== 1'b1 || instr_out !== 32'h0050_0093 || pc_out !== 32'h0 || imem_req !== 1'b0) begin
      n_fail++; $display("FAIL first_fetch: valid=%b instr=%h pc=%h req=%b required 1/00500093/0/0", instr_valid, instr_out, pc_out, imem_req);
    end
  endtask

  task automatic test_sequential();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      wait_req();
      n_chk++;
      if (imem_addr !== 32'(i * 4)) begin n_fail++; $display("FAIL seq_addr%0d: addr=%h required %h", i, imem_addr, i * 4); end
      repeat (2) begin
        @(negedge clk);
        n_chk++;
        if (imem_req !== 1'b1 || imem_addr !== 32'(i * 4)) begin n_fail++; $display("FAIL seq_stable%0d: req=%b addr=%h required 1/%h", i, imem_req, imem_addr, i * 4); end
      end
      ack_word(32'h100 + 32'(i), 0);
      repeat (2) @(negedge clk);
      n_chk++;
      if (instr_valid !== 1'b1 || instr_out !== 32'h100 + 32'(i)) begin n_fail++; $display("FAIL seq_instr%0d: valid=%b instr=%h required 1/%h", i, instr_valid, instr_out, 32'h100 + i); end
      retire(2'b00, 0, 0, 0);
    end
    n_chk++;
    if (instret !== 32'd3) begin n_fail++; $display("FAIL seq_instret: instret=%0d required 3", instret); end
    wait_req();
    n_chk++;
    if (imem_addr !== 32'hC) begin n_fail++; $display("FAIL seq_next: addr=%h required c", imem_addr); end
  endtask

  task automatic test_branch_jalr();
    do_reset();
    wait_req(); ack_word(32'h13, 0); retire(2'b11, 0, 32'h20, 0);
    wait_req();
    n_chk++;
    if (imem_addr !== 32'h20) begin n_fail++; $display("FAIL jal_target: addr=%h required 20", imem_addr); end
    ack_word(32'h13, 0); retire(2'b01, 1, -32'sd8, 0);
    wait_req();
    n_chk++;
    if (imem_addr !== 32'h18) begin n_fail++; $display("FAIL br_taken: addr=%h required 18", imem_addr); end
    ack_word(32'h13, 0); retire(2'b11, 0, 32'h8, 0);
    wait_req(); ack_word(32'h13, 0);
    n_chk++;
    if (pc_out !== 32'h20) begin n_fail++; $display("FAIL jal_back: pc=%h required 20", pc_out); end
    retire(2'b01, 0, -32'sd8, 0);
    wait_req();
    n_chk++;
    if (imem_addr !== 32'h24) begin n_fail++; $display("FAIL br_not_taken: addr=%h required 24", imem_addr); end
    ack_word(32'h13, 0); retire(2'b10, 0, 32'h1, 32'h103);
    wait_req();
    n_chk++;
    if (imem_addr !== 32'h104) begin n_fail++; $display("FAIL jalr_target: addr=%h required 104", imem_addr); end
    ack_word(32'h13, 0); retire(2'b10, 0, 32'h1, 32'h101);
    n_chk++;
    if ({trap, trap_cause, instr_valid, imem_req} !== 5'b10100 || pc_out !== 32'h104 || instret !== 32'd6) begin
      n_fail++; $display("FAIL jalr_misalign: trap/cause/valid/req=%b pc=%h instret=%0d required 10100/104/6", {trap, trap_cause, instr_valid, imem_req}, pc_out, instret);
    end
    imem_ack = 1; instr_ready = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_chk++;
      if ({trap, trap_cause, imem_req, instr_valid} !== 5'b10100 || pc_out !== 32'h104) begin
        n_fail++; $display("FAIL trap_hold%0d: trap/cause/req/valid=%b pc=%h required 10100/104", i, {trap, trap_cause, imem_req, instr_valid}, pc_out);
      end
    end
    imem_ack = 0; instr_ready = 0;
  endtask

  task automatic test_jal_misaligned();
    do_reset();
    wait_req(); ack_word(32'h6f, 0); retire(2'b11, 0, 32'h6, 0);
    n_chk++;
    if ({trap, trap_cause} !== 3'b101 || pc_out !== 32'h0 || instret !== 32'd1) begin
      n_fail++; $display("FAIL jal_misalign: trap/cause=%b pc=%h instret=%0d required 101/0/1", {trap, trap_cause}, pc_out, instret);
    end
  endtask

  task automatic test_imem_err();
    logic seen_valid;
    do_reset();
    wait_req(); ack_word(32'hDEAD_BEEF, 1);
    seen_valid = instr_valid;
    n_chk++;
    if ({trap, trap_cause, imem_req} !== 4'b1100 || instret !== 32'd0) begin
      n_fail++; $display("FAIL imem_err: trap/cause/req=%b instret=%0d required 1100/0", {trap, trap_cause, imem_req}, instret);
    end
    repeat (3) begin @(negedge clk); seen_valid |= instr_valid; end
    n_chk++;
    if (seen_valid !== 1'b0) begin n_fail++; $display("FAIL imem_err_valid: instr_valid rose=%b required 0", seen_valid); end
  endtask

  task automatic test_reset_mid_fetch();
    do_reset();
    wait_req(); ack_word(32'h13, 0); retire(2'b00, 0, 0, 0);
    wait_req();
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    n_chk++;
    if (imem_req !== 1'b0 || pc_out !== 32'h0) begin n_fail++; $display("FAIL mid_rst: req=%b pc=%h required 0/0", imem_req, pc_out); end
    rst = 0; imem_ack = 1; imem_rdata = 32'hDEAD_DEAD;
    @(negedge clk);
    imem_ack = 0; imem_rdata = 0;
    n_chk++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
      n_fail++; $display("FAIL late_ack: req=%b addr=%h valid=%b required 1/0/0", imem_req, imem_addr, instr_valid);
    end
    ack_word(32'h33, 0);
    n_chk++;
    if (instr_out !== 32'h33 || pc_out !== 32'h0 || instr_valid !== 1'b1) begin
      n_fail++; $display("FAIL restart_fetch: instr=%h pc=%h valid=%b required 33/0/1", instr_out, pc_out, instr_valid);
    end
  endtask

  task automatic test_instret_wrap();
    do_reset();
    wait_req(); ack_word(32'h13, 0);
    force dut.instret_q = 32'hFFFF_FFFF;
    #1 release dut.instret_q;
    n_chk++;
    if (instret !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_preload: instret=%h required ffffffff", instret); end
    @(negedge clk);
    retire(2'b00, 0, 0, 0);
    n_chk++;
    if (instret !== 32'h0 || trap !== 1'b0) begin n_fail++; $display("FAIL wrap: instret=%h trap=%b required 0/0", instret, trap); end
    wait_req();
    n_chk++;
    if (imem_addr !== 32'h4) begin n_fail++; $display("FAIL wrap_next: addr=%h required 4", imem_addr); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch_jalr();
    test_jal_misaligned();
    test_imem_err();
    test_reset_mid_fetch();
    test_instret_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
